// File: rtl/axis_pkt_gen_pkg.sv
// rtl/axis_pkt_gen_pkg.sv - shared types and defaults for the AXI-Stream packet generator
package axis_pkt_gen_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH  = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_FIN
  } state_e;

endpackage

// File: rtl/axis_pkt_gen_if.sv
// rtl/axis_pkt_gen_if.sv - stream interface carrying generated packet beats
interface axis_pkt_gen_if
  import axis_pkt_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_pkt_gen.sv
// rtl/axis_pkt_gen.sv - run-based packet generator emitting an incrementing data stream
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [15:0]           pkt_count,
  input  logic [7:0]            gap,
  input  logic [DATA_WIDTH-1:0] seed,
  axis_pkt_gen_if.master        m_axis,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           pkts_sent
);

  localparam int BW = LEN_WIDTH + 1;

  state_e                state_q, state_d;
  logic [BW-1:0]         len_q, len_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [15:0]           count_q, count_d;
  logic [7:0]            gap_q, gap_d;
  logic [7:0]            gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  abort_q, abort_d;
  logic [15:0]           sent_q, sent_d;

  logic [BW-1:0]         len_start;
  logic                  fire;
  logic                  abort_seen;

  // A zero length field encodes the full 2^LEN_WIDTH beat packet.
  assign len_start  = (pkt_len == '0) ? (BW'(1) << LEN_WIDTH) : {1'b0, pkt_len};
  assign fire       = valid_q & m_axis.tready;
  assign abort_seen = abort_q | abort;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    beat_d    = beat_q;
    count_d   = count_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    abort_d   = abort_q;
    sent_d    = sent_q;

    unique case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          len_d   = len_start;
          count_d = pkt_count;
          gap_d   = gap;
          data_d  = seed;
          beat_d  = '0;
          sent_d  = '0;
          if (pkt_count == 16'd0) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_SEND;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            last_d  = (len_start == BW'(1));
          end
        end
      end

      ST_SEND: begin
        abort_d = abort_seen;
        if (fire) begin
          data_d = data_q + DATA_WIDTH'(1);
          if (last_q) begin
            sent_d = sent_q + 16'd1;
            beat_d = '0;
            if ((sent_q + 16'd1 == count_q) || abort_seen) begin
              state_d = ST_FIN;
              valid_d = 1'b0;
              last_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (gap_q != 8'd0) begin
              state_d   = ST_GAP;
              valid_d   = 1'b0;
              last_d    = 1'b0;
              gap_cnt_d = gap_q;
            end else begin
              last_d = (len_q == BW'(1));
            end
          end else begin
            beat_d = beat_q + BW'(1);
            last_d = (beat_q + BW'(2) == len_q);
          end
        end
      end

      ST_GAP: begin
        abort_d = abort_seen;
        if (abort_seen) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (gap_cnt_q == 8'd1) begin
          state_d = ST_SEND;
          valid_d = 1'b1;
          last_d  = (len_q == BW'(1));
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
        abort_d = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      beat_q    <= '0;
      count_q   <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      sent_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      count_q   <= count_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      sent_q    <= sent_d;
    end
  end

  assign m_axis.tdata  = data_q;
  assign m_axis.tvalid = valid_q;
  assign m_axis.tlast  = last_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pkts_sent     = sent_q;

endmodule

// File: doc/axis_pkt_gen.md
AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, stream data width in bits.
REQ-002 SHALL have parameter LEN_WIDTH, default 11, packet-length field width (max 2048 beats).
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 start  input  1  launch a run; sampled only in IDLE.
REQ-006 abort  input  1  stop the run at the next packet boundary.
REQ-007 pkt_len  input  LEN_WIDTH  beats per packet; 0 means 2^LEN_WIDTH beats.
REQ-008 pkt_count  input  16  packets per run.
REQ-009 gap  input  8  idle cycles between packets.
REQ-010 seed  input  DATA_WIDTH  data value of the first beat of the run.
REQ-011 m_axis_data  output  DATA_WIDTH  stream payload.
REQ-012 m_axis_valid  output  1  beat valid.
REQ-013 m_axis_ready  input  1  downstream ready.
REQ-014 m_axis_last  output  1  final beat of a packet.
REQ-015 busy  output  1  run in progress.
REQ-016 done  output  1  one-cycle end-of-run pulse.
REQ-017 pkts_sent  output  16  packets completed in the current or last run.

Function
REQ-018 SHALL implement the FSM states IDLE, SEND, GAP and FIN.
REQ-019 IDLE: start=1 SHALL latch pkt_len, pkt_count, gap and seed, clear pkts_sent, and enter SEND; busy and m_axis_valid SHALL be 1 on the next cycle.
REQ-020 IDLE with start=1 and pkt_count=0 SHALL enter FIN directly with no beats.
REQ-021 SEND: m_axis_valid SHALL be 1 regardless of m_axis_ready.
REQ-022 A beat is transferred only when m_axis_valid=1 and m_axis_ready=1; otherwise data, valid and last SHALL hold unchanged.
REQ-023 Beat k of the run (k counting from 0 across all packets) SHALL carry seed+k modulo 2^DATA_WIDTH.
REQ-024 m_axis_last SHALL be 1 exactly on the final beat of each packet, including 1-beat packets.
REQ-025 On the transferred last beat, pkts_sent SHALL increment.
REQ-026 Next state after the transferred last beat: FIN if the run is complete or abort was latched; else GAP if gap>0; else SEND, with the next beat presented on the next cycle and no valid bubble.
REQ-027 GAP SHALL hold m_axis_valid=0 for exactly gap cycles, then enter SEND.
REQ-028 abort=1 in any non-IDLE cycle SHALL be latched; the current packet completes fully with correct last; if in GAP, SHALL enter FIN at the next cycle.
REQ-029 FIN SHALL last one cycle with done=1, busy=0 and valid=0, then return to IDLE.
REQ-030 start outside IDLE SHALL be ignored.
REQ-031 Inputs other than start and abort SHALL be ignored except when latched in IDLE.
REQ-032 The beat counter SHALL be LEN_WIDTH+1 bits so that pkt_len=0 yields 2^LEN_WIDTH beats.

Reset
REQ-033 reset_n=0 at a clock edge SHALL force IDLE and set m_axis_valid, m_axis_last, busy and done to 0, and m_axis_data and pkts_sent to 0.
REQ-034 Reset mid-packet SHALL drop valid at the next edge with no last beat emitted and clear any latched abort.

Structure
REQ-035 Package axis_pkt_gen_pkg SHALL hold the FSM state typedef and the default DATA_WIDTH and LEN_WIDTH constants.
REQ-036 The block SHALL be a single module with no sub-module; all outputs SHALL be registered.

Verification
REQ-037 seed=0x100, pkt_len=4, pkt_count=2, gap=0, ready=1 -> data 0x100..0x107, last on 0x103 and 0x107, valid continuous for 8 cycles, done one cycle later, pkts_sent=2.
REQ-038 Same configuration with gap=3 -> exactly 3 valid=0 cycles between 0x103 and 0x104.
REQ-039 pkt_len=3, ready toggling 1,0,0,1,... -> data and last stable while ready=0; sequence identical to the ready=1 case.
REQ-040 pkt_len=5, pkt_count=10, abort pulsed at beat 2 of packet 1 -> packet 1 completes with last, no further valid, done pulses, pkts_sent=2.
REQ-041 pkt_len=0, pkt_count=1 -> 2048 beats, last only on beat 2047; pkt_count=0 -> done with no valid.
REQ-042 reset_n=0 mid-packet -> next cycle valid=0, busy=0, pkts_sent=0; a new start runs cleanly from seed.
